// File: rtl/x_dl_pkg.sv
// Shared types and constants for the delay-line calibration controller.
package x_dl_pkg;

    // Edge positions span 1..256, so nine bits are needed.
    localparam int unsigned PosW = 9;
    localparam logic [PosW-1:0] PosInit = 9'd511;

    typedef enum logic [2:0] {
        StIdle,
        StCapt,
        StScan,
        StAcc,
        StOut
    } dl_state_e;

endpackage

// File: rtl/x_dl_edge_scan.sv
// Holds one delay-line snapshot and walks it one tap per cycle to find the first
// tap that differs from tap 0.
module x_dl_edge_scan
    import x_dl_pkg::*;
#(
    parameter int unsigned p_length = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                capt_i,
    input  logic                scan_i,
    input  logic [p_length-1:0] data_i,
    output logic [PosW-1:0]     pos_o,
    output logic                done_o
);

    localparam int unsigned IdxW = (p_length > 2) ? $clog2(p_length) : 1;

    logic [p_length-1:0] scan_q, scan_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [PosW-1:0]     pos_q, pos_d;
    logic                mismatch;
    logic                last;

    always_comb begin
        scan_d   = scan_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        mismatch = (scan_q[idx_q] != scan_q[0]);
        last     = (idx_q == IdxW'(p_length - 1));
        done_o   = scan_i && (mismatch || last);

        if (capt_i) begin
            scan_d = data_i;
            idx_d  = IdxW'(1);
        end else if (scan_i) begin
            if (done_o) begin
                // A full pass with no mismatch reports p_length as the position.
                pos_d = mismatch ? PosW'(idx_q) : PosW'(p_length);
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scan_q <= '0;
            idx_q  <= '0;
            pos_q  <= '0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            pos_q  <= pos_d;
        end
    end

    // Registered so the position stays stable through the accumulate cycle.
    assign pos_o = pos_q;

endmodule

// File: rtl/x_dl_cal_ctrl.sv
// Calibration controller: captures p_samples delay-line snapshots, gathers
// min/max/mean edge position and no-edge count, and hands the result off.
module x_dl_cal_ctrl
    import x_dl_pkg::*;
#(
    parameter int unsigned p_length  = 256,
    parameter int unsigned p_samples = 16
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_start,
    input  logic [p_length-1:0] i_data,
    output logic                o_busy,
    output logic [PosW-1:0]     o_min,
    output logic [PosW-1:0]     o_max,
    output logic [PosW-1:0]     o_mean,
    output logic [PosW-1:0]     o_noedge,
    output logic                o_valid,
    input  logic                i_ready
);

    localparam int unsigned SampW = $clog2(p_samples);
    localparam int unsigned SumW  = PosW + SampW;

    dl_state_e state_q, state_d;

    logic [PosW-1:0] min_q, min_d;
    logic [PosW-1:0] max_q, max_d;
    logic [SumW-1:0] sum_q, sum_d;
    logic [PosW-1:0] noedge_q, noedge_d;
    logic [PosW-1:0] cnt_q, cnt_d;

    logic [PosW-1:0] res_min_q, res_min_d;
    logic [PosW-1:0] res_max_q, res_max_d;
    logic [PosW-1:0] res_mean_q, res_mean_d;
    logic [PosW-1:0] res_noedge_q, res_noedge_d;

    logic [SumW-1:0] sum_shift;
    logic [PosW-1:0] pos;
    logic            scan_done;
    logic            capt;
    logic            scan_en;

    x_dl_edge_scan #(
        .p_length (p_length)
    ) u_edge_scan (
        .clk_i  (i_clk),
        .rst_ni (i_nrst),
        .capt_i (capt),
        .scan_i (scan_en),
        .data_i (i_data),
        .pos_o  (pos),
        .done_o (scan_done)
    );

    always_comb begin
        state_d      = state_q;
        min_d        = min_q;
        max_d        = max_q;
        sum_d        = sum_q;
        noedge_d     = noedge_q;
        cnt_d        = cnt_q;
        res_min_d    = res_min_q;
        res_max_d    = res_max_q;
        res_mean_d   = res_mean_q;
        res_noedge_d = res_noedge_q;
        sum_shift    = '0;
        capt         = 1'b0;
        scan_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d  = StCapt;
                    min_d    = PosInit;
                    max_d    = '0;
                    sum_d    = '0;
                    noedge_d = '0;
                    cnt_d    = '0;
                end
            end
            StCapt: begin
                capt    = 1'b1;
                state_d = StScan;
            end
            StScan: begin
                scan_en = 1'b1;
                if (scan_done) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (pos < min_q) begin
                    min_d = pos;
                end
                if (pos > max_q) begin
                    max_d = pos;
                end
                sum_d = sum_q + SumW'(pos);
                if (pos == PosW'(p_length)) begin
                    noedge_d = noedge_q + PosW'(1);
                end
                cnt_d = cnt_q + PosW'(1);
                if (cnt_d < PosW'(p_samples)) begin
                    state_d = StCapt;
                end else begin
                    // Results are latched only here, so an aborted run never leaks out.
                    state_d      = StOut;
                    sum_shift    = sum_d >> SampW;
                    res_min_d    = min_d;
                    res_max_d    = max_d;
                    res_mean_d   = sum_shift[PosW-1:0];
                    res_noedge_d = noedge_d;
                end
            end
            StOut: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= StIdle;
            min_q        <= '0;
            max_q        <= '0;
            sum_q        <= '0;
            noedge_q     <= '0;
            cnt_q        <= '0;
            res_min_q    <= '0;
            res_max_q    <= '0;
            res_mean_q   <= '0;
            res_noedge_q <= '0;
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            max_q        <= max_d;
            sum_q        <= sum_d;
            noedge_q     <= noedge_d;
            cnt_q        <= cnt_d;
            res_min_q    <= res_min_d;
            res_max_q    <= res_max_d;
            res_mean_q   <= res_mean_d;
            res_noedge_q <= res_noedge_d;
        end
    end

    assign o_busy   = (state_q != StIdle);
    assign o_valid  = (state_q == StOut);
    assign o_min    = res_min_q;
    assign o_max    = res_max_q;
    assign o_mean   = res_mean_q;
    assign o_noedge = res_noedge_q;

endmodule

// File: tb/tb_x_dl_cal_ctrl.sv
// Self-checking bench for x_dl_cal_ctrl: a 16-sample and a 2-sample instance,
// expected results queued at run start and compared when o_valid appears.
module tb_x_dl_cal_ctrl;

    localparam int L   = 256;
    localparam int S   = 16;
    localparam int S2  = 2;
    localparam int TMO = 10000;

    typedef struct packed {
        logic [8:0] mn;
        logic [8:0] mx;
        logic [8:0] mean;
        logic [8:0] ne;
    } res_t;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start_a, ready_a, busy_a, valid_a;
    logic [L-1:0] data_a;
    logic [8:0]   min_a, max_a, mean_a, noedge_a;
    logic         start_b, ready_b, busy_b, valid_b;
    logic [L-1:0] data_b;
    logic [8:0]   min_b, max_b, mean_b, noedge_b;

    int   total = 0;
    int   bad = 0;
    res_t sb[$];
    res_t last_exp;

    always #5 clk = ~clk;

    x_dl_cal_ctrl #(.p_length(L), .p_samples(S)) dut_a (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_a), .i_data(data_a), .o_busy(busy_a),
        .o_min(min_a), .o_max(max_a), .o_mean(mean_a), .o_noedge(noedge_a),
        .o_valid(valid_a), .i_ready(ready_a)
    );

    x_dl_cal_ctrl #(.p_length(L), .p_samples(S2)) dut_b (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_b), .i_data(data_b), .o_busy(busy_b),
        .o_min(min_b), .o_max(max_b), .o_mean(mean_b), .o_noedge(noedge_b),
        .o_valid(valid_b), .i_ready(ready_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] edge_vec(input int p, input bit inv);
        logic [L-1:0] v;
        v = '0;
        for (int i = 0; i < p; i++) v[i] = 1'b1;
        if (inv) v = ~v;
        return v;
    endfunction

    function automatic int ref_pos(input logic [L-1:0] d);
        for (int i = 1; i < L; i++) if (d[i] !== d[0]) return i;
        return L;
    endfunction

    function automatic res_t model_run(input int n, input int p0, input int p1);
        int mn, mx, sum, ne, p;
        res_t r;
        mn = 511; mx = 0; sum = 0; ne = 0;
        for (int k = 0; k < n; k++) begin
            p = (k % 2 == 0) ? p0 : p1;
            if (p < mn) mn = p;
            if (p > mx) mx = p;
            sum += p;
            if (p == L) ne++;
        end
        r.mn = 9'(mn); r.mx = 9'(mx); r.mean = 9'(sum / n); r.ne = 9'(ne);
        return r;
    endfunction

    function automatic int exp_latency(input int n, input int p);
        int scan;
        scan = (p < L - 1) ? p : L - 1;
        return n * (scan + 2) + 1;
    endfunction

    task automatic run_a(input int pulse_at, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        start_a = 1'b1;
        while (cyc < TMO) begin
            step();
            cyc++;
            start_a = (cyc == pulse_at);
            if (valid_a) begin
                ok = 1'b1;
                break;
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if ({busy_a, valid_a, min_a, max_a, mean_a, noedge_a} !== '0) begin
            bad++;
            $display("FAIL reset_a: got %h want 0", {busy_a, valid_a, min_a, max_a, mean_a, noedge_a});
        end
        total++;
        if ({busy_b, valid_b, min_b, max_b, mean_b, noedge_b} !== '0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0", {busy_b, valid_b, min_b, max_b, mean_b, noedge_b});
        end
        nrst = 1'b1;
        repeat (3) step();
        total++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy %b%b want 00", busy_a, busy_b);
        end
    endtask

    task automatic test_edge100();
        int cyc, want;
        bit ok;
        res_t got;
        data_a = edge_vec(100, 1'b0);
        sb.push_back(model_run(S, ref_pos(data_a), ref_pos(data_a)));
        want = exp_latency(S, ref_pos(data_a));
        run_a(0, cyc, ok);
        total++;
        if (!ok || cyc != want) begin
            bad++;
            $display("FAIL edge100_latency: got %0d cycles (ok=%0d) want %0d", cyc, ok, want);
        end
        last_exp = sb.pop_front();
        got = {min_a, max_a, mean_a, noedge_a};
        total++;
        if (got !== last_exp) begin
            bad++;
            $display("FAIL edge100_result: got %h want %h", got, last_exp);
        end
    endtask

    task automatic test_hold();
        res_t got;
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            got = {min_a, max_a, mean_a, noedge_a};
            total++;
            if (valid_a !== 1'b1 || got !== last_exp) begin
                bad++;
                $display("FAIL hold_%0d: got valid=%b res=%h want valid=1 res=%h", i, valid_a, got,
                         last_exp);
            end
        end
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
        total++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL handshake_idle: got valid=%b busy=%b want 0 0", valid_a, busy_a);
        end
        step();
        got = {min_a, max_a, mean_a, noedge_a};
        total++;
        if (got !== last_exp) begin
            bad++;
            $display("FAIL idle_retain: got %h want %h", got, last_exp);
        end
    endtask

    task automatic test_start_in_scan();
        int cyc, want;
        bit ok;
        res_t got, exp;
        data_a = edge_vec(100, 1'b0);
        sb.push_back(model_run(S, ref_pos(data_a), ref_pos(data_a)));
        want = exp_latency(S, ref_pos(data_a));
        run_a(20, cyc, ok);
        total++;
        if (!ok || cyc != want) begin
            bad++;
            $display("FAIL scan_start_latency: got %0d cycles (ok=%0d) want %0d", cyc, ok, want);
        end
        exp = sb.pop_front();
        got = {min_a, max_a, mean_a, noedge_a};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL scan_start_result: got %h want %h", got, exp);
        end
        ready_a = 1'b1;
        start_a = 1'b1;
        step();
        ready_a = 1'b0;
        start_a = 1'b0;
        step();
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL start_in_handshake: got busy=%b valid=%b want 0 0", busy_a, valid_a);
        end
    endtask

    task automatic test_noedge();
        int cyc, want;
        bit ok;
        res_t got, exp;
        data_a = '0;
        sb.push_back(model_run(S, ref_pos(data_a), ref_pos(data_a)));
        want = exp_latency(S, ref_pos(data_a));
        run_a(0, cyc, ok);
        total++;
        if (!ok || cyc != want) begin
            bad++;
            $display("FAIL noedge_latency: got %0d cycles (ok=%0d) want %0d", cyc, ok, want);
        end
        exp = sb.pop_front();
        got = {min_a, max_a, mean_a, noedge_a};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL noedge_result: got %h want %h", got, exp);
        end
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
    endtask

    task automatic test_alternate();
        int cyc, want;
        bit ok;
        res_t got, exp;
        logic [L-1:0] e10, e20;
        e10 = edge_vec(10, 1'b0);
        e20 = edge_vec(20, 1'b1);
        sb.push_back(model_run(S2, ref_pos(e10), ref_pos(e20)));
        want = 1 + (ref_pos(e10) + 2) + (ref_pos(e20) + 2);
        data_b = e10;
        start_b = 1'b1;
        ok = 1'b0;
        cyc = 0;
        while (cyc < TMO) begin
            step();
            cyc++;
            start_b = 1'b0;
            if (cyc == 5) data_b = e20;
            if (valid_b) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || cyc != want) begin
            bad++;
            $display("FAIL alt_latency: got %0d cycles (ok=%0d) want %0d", cyc, ok, want);
        end
        exp = sb.pop_front();
        got = {min_b, max_b, mean_b, noedge_b};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL alt_result: got %h want %h", got, exp);
        end
        ready_b = 1'b1;
        step();
        ready_b = 1'b0;
        total++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
            bad++;
            $display("FAIL alt_handshake: got busy=%b valid=%b want 0 0", busy_b, valid_b);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, want, p;
        bit ok;
        res_t got, exp;
        data_a = edge_vec(100, 1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (30) step();
        nrst = 1'b0;
        #1;
        total++;
        if ({busy_a, valid_a, min_a, max_a, mean_a, noedge_a} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", {busy_a, valid_a, min_a, max_a, mean_a, noedge_a});
        end
        step();
        nrst = 1'b1;
        repeat (5) step();
        total++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL abort_wait_start: got busy=%b valid=%b want 0 0", busy_a, valid_a);
        end
        p = $urandom_range(255, 1);
        data_a = edge_vec(p, 1'($urandom_range(1, 0)));
        sb.push_back(model_run(S, ref_pos(data_a), ref_pos(data_a)));
        want = exp_latency(S, ref_pos(data_a));
        run_a(0, cyc, ok);
        total++;
        if (!ok || cyc != want) begin
            bad++;
            $display("FAIL fresh_latency: got %0d cycles (ok=%0d) want %0d", cyc, ok, want);
        end
        exp = sb.pop_front();
        got = {min_a, max_a, mean_a, noedge_a};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL fresh_result: got %h want %h", got, exp);
        end
        ready_a = 1'b1;
        step();
        ready_a = 1'b0;
    endtask

    initial begin
        nrst    = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b0;
        data_a  = '0;
        start_b = 1'b0;
        ready_b = 1'b0;
        data_b  = '0;
        test_reset();
        test_edge100();
        test_hold();
        test_start_in_scan();
        test_noedge();
        test_alternate();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
